// File: rtl/efi_pe_pkg.sv
// Shared PE definitions: DSP result, accumulator and PE output widths plus
// the signed types used by the DSP wrapper, this accumulator and the output
// feature writer.
package efi_pe_pkg;

    localparam int EFI_DSP_RES_W = 32;  // signed sum-of-two result from the DSP
    localparam int EFI_ACC_W     = 44;  // signed dot-product accumulator
    localparam int EFI_PE_OUT_W  = 16;  // signed PE output feature
    localparam int EFI_SHIFT_W   = 5;   // runtime fractional right-shift control

    typedef logic signed [EFI_DSP_RES_W-1:0] efi_dsp_res_t;
    typedef logic signed [EFI_ACC_W-1:0]     efi_acc_t;
    typedef logic signed [EFI_PE_OUT_W-1:0]  efi_pe_out_t;
    typedef logic        [EFI_SHIFT_W-1:0]   efi_shift_t;

    // Finished dot product waiting for round/saturate.
    typedef struct packed {
        efi_acc_t   sum;
        efi_shift_t shift;
    } efi_acc_result_t;

    // Final PE output word with its clip flag.
    typedef struct packed {
        efi_pe_out_t data;
        logic        sat;
    } efi_pe_result_t;

    // log2 of the number of beats an accumulator can absorb without wrapping.
    function automatic int efi_beat_limit_log2(input int acc_w, input int in_w);
        return acc_w - in_w;
    endfunction

endpackage

// File: rtl/efi_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation of a
// finished accumulator value down to the PE output width. The rounding add is
// done one bit wider than the accumulator so it can never wrap.
module efi_round_sat
    import efi_pe_pkg::*;
#(
    parameter int ACC_W   = EFI_ACC_W,
    parameter int OUT_W   = EFI_PE_OUT_W,
    parameter int SHIFT_W = EFI_SHIFT_W
) (
    input  logic signed [ACC_W-1:0]   sum_i,
    input  logic        [SHIFT_W-1:0] shift_i,
    output logic signed [OUT_W-1:0]   data_o,
    output logic                      sat_o
);

    localparam int EXT_W = ACC_W + 1;

    // Output range expressed at the extended width for signed comparison.
    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN =
        {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic        [EXT_W-1:0] EXT_ONE = {{(EXT_W-1){1'b0}}, 1'b1};

    logic signed [EXT_W-1:0] sum_ext;
    logic signed [EXT_W-1:0] bias;
    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;

    // Add half an output LSB, shift arithmetically, then clamp to OUT_W.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        sum_ext = {sum_i[ACC_W-1], sum_i};
        bias    = '0;
        if (shift_i != '0) begin
            bias = EXT_ONE << (shift_i - SHIFT_W'(1));
        end
        biased  = sum_ext + bias;
        shifted = biased >>> shift_i;

        data_o = shifted[OUT_W-1:0];
        sat_o  = 1'b0;
        if (shifted > SAT_MAX) begin
            data_o = SAT_MAX[OUT_W-1:0];
            sat_o  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            data_o = SAT_MIN[OUT_W-1:0];
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/efi_dot_product_accumulator.sv
// Consumer side of the 16x16 signed dot-product DSP. Accumulates 32-bit
// partial-sum beats until 'last' (stage A), then registers the rounded,
// shifted and saturated result (stage B). A single stall condition derived
// from the output register gates both stages and in_ready.
module efi_dot_product_accumulator
    import efi_pe_pkg::*;
#(
    parameter int IN_W    = EFI_DSP_RES_W,
    parameter int ACC_W   = EFI_ACC_W,
    parameter int OUT_W   = EFI_PE_OUT_W,
    parameter int SHIFT_W = EFI_SHIFT_W
) (
    input  logic                      clk0,
    input  logic                      aclr0_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [IN_W-1:0]    in_data,
    input  logic                      in_last,
    input  logic        [SHIFT_W-1:0] frac_shift,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   out_data,
    output logic                      out_sat,
    output logic                      ovf_err
);

    // Beat counter holds 0 .. 2^(ACC_W-IN_W); the top value is the no-wrap limit.
    localparam int CNT_W = efi_beat_limit_log2(ACC_W, IN_W) + 1;
    localparam logic [CNT_W-1:0] BEAT_LIMIT = {1'b1, {(CNT_W-1){1'b0}}};

    // Handshake and stall.
    logic stb_adv;
    logic xfer;

    // Stage A: running accumulator and finished-sum register.
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic signed [ACC_W-1:0]   beat_sum;
    logic                      va_q, va_d;
    logic signed [ACC_W-1:0]   sum_a_q, sum_a_d;
    logic        [SHIFT_W-1:0] shift_a_q, shift_a_d;
    logic                      ovf_err_q, ovf_err_d;

    // Stage B: registered output.
    logic                      out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]   out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;

    // Round/saturate of the stage A result.
    logic signed [OUT_W-1:0]   rs_data;
    logic                      rs_sat;

    // Stage B moves when it is empty or its word is being taken. Stage A is
    // free when empty or draining into stage B; in_ready never depends on in_valid.
    assign stb_adv  = !out_valid_q || out_ready;
    assign in_ready = !va_q || stb_adv;
    assign xfer     = in_valid && in_ready;
    assign beat_sum = acc_q + {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};

    efi_round_sat #(
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
    ) u_round_sat (
        .sum_i   (sum_a_q),
        .shift_i (shift_a_q),
        .data_o  (rs_data),
        .sat_o   (rs_sat)
    );

    // Stage A next state: accumulate, close a vector on last, track overflow.
    always_comb begin
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        va_d       = va_q;
        sum_a_d    = sum_a_q;
        shift_a_d  = shift_a_q;
        ovf_err_d  = ovf_err_q;

        if (stb_adv) begin
            va_d = 1'b0;
        end

        if (xfer) begin
            if (beat_cnt_q == BEAT_LIMIT) begin
                ovf_err_d = 1'b1;
            end
            if (in_last) begin
                // Counter clears here, so the next vector may start next cycle.
                sum_a_d    = beat_sum;
                shift_a_d  = frac_shift;
                va_d       = 1'b1;
                acc_d      = '0;
                beat_cnt_d = '0;
            end else begin
                acc_d = beat_sum;
                if (beat_cnt_q != BEAT_LIMIT) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Stage B next state: load the rounded result when the output register advances.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (stb_adv) begin
            out_valid_d = va_q;
            if (va_q) begin
                out_data_d = rs_data;
                out_sat_d  = rs_sat;
            end
        end
    end

    // All pipeline state; reset discards any partial or pending result.
    always_ff @(posedge clk0 or negedge aclr0_n) begin
        if (!aclr0_n) begin
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            va_q        <= 1'b0;
            sum_a_q     <= '0;
            shift_a_q   <= '0;
            ovf_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            acc_q       <= acc_d;
            beat_cnt_q  <= beat_cnt_d;
            va_q        <= va_d;
            sum_a_q     <= sum_a_d;
            shift_a_q   <= shift_a_d;
            ovf_err_q   <= ovf_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign ovf_err   = ovf_err_q;

endmodule
